// File: rtl/dds_key_ctrl.sv
// DDS configuration controller: debounces two active-low keys and
// hands wave/frequency settings to the DDS core over valid/ready.
//
// Ports:
//   sys_clk, sys_rst      clock, async active-high reset
//   key0, key1            raw active-low buttons (wave / frequency)
//   wave_sel[1:0]         0 sine, 1 square, 2 triangle, 3 sawtooth
//   freq_level[2:0]       frequency level 0..NUM_LEVELS-1
//   freq_word[FW_WIDTH]   FW_BASE*(freq_level+1), truncated
//   cfg_valid, cfg_ready  configuration handshake

// One key path: 2-FF synchronizer, debounce counter, press pulse.
module dds_key_deb #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          acc_q, acc_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count cycles where the synced level differs from the accepted
  // level; any return to the accepted level restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (sync2_q == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      acc_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d = acc_q & ~acc_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

module dds_key_ctrl #(
  parameter int unsigned          DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned          FW_WIDTH        = 32,
  parameter logic [FW_WIDTH-1:0]  FW_BASE         = 32'd85_899,
  parameter int unsigned          NUM_LEVELS      = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                key0,
  input  logic                key1,
  output logic [1:0]          wave_sel,
  output logic [2:0]          freq_level,
  output logic [FW_WIDTH-1:0] freq_word,
  output logic                cfg_valid,
  input  logic                cfg_ready
);

  localparam logic [2:0] LVL_LAST = 3'(NUM_LEVELS - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_UPDATE
  } state_e;

  state_e              state_q, state_d;
  logic                press0, press1;
  logic                pend0_q, pend0_d;
  logic                pend1_q, pend1_d;
  logic [1:0]          wave_q, wave_d;
  logic [2:0]          level_q, level_d;
  logic [FW_WIDTH-1:0] fw_q, fw_d;
  logic                valid_q, valid_d;

  dds_key_deb #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb0 (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .key_i  (key0),
    .press_o(press0)
  );

  dds_key_deb #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb1 (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .key_i  (key1),
    .press_o(press1)
  );

  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    level_d = level_q;
    fw_d    = fw_q;
    valid_d = valid_q;
    // Flags saturate; a press on the apply edge re-arms its flag.
    pend0_d = pend0_q | press0;
    pend1_d = pend1_q | press1;
    unique case (state_q)
      S_INIT: begin
        valid_d = 1'b1;
        state_d = S_UPDATE;
      end
      S_IDLE: begin
        if (pend0_q || pend1_q) begin
          if (pend0_q) begin
            wave_d  = wave_q + 2'd1;
            pend0_d = press0;
          end
          if (pend1_q) begin
            pend1_d = press1;
            if (level_q == LVL_LAST) begin
              level_d = '0;
              fw_d    = FW_BASE;
            end else begin
              level_d = level_q + 3'd1;
              fw_d    = fw_q + FW_BASE;
            end
          end
          valid_d = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (valid_q && cfg_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_INIT;
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      wave_q  <= '0;
      level_q <= '0;
      fw_q    <= FW_BASE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend0_q <= pend0_d;
      pend1_q <= pend1_d;
      wave_q  <= wave_d;
      level_q <= level_d;
      fw_q    <= fw_d;
      valid_q <= valid_d;
    end
  end

  assign wave_sel   = wave_q;
  assign freq_level = level_q;
  assign freq_word  = fw_q;
  assign cfg_valid  = valid_q;

endmodule
